fifo_rr_scheduler: RTL

//  Round-robin read scheduler that drains four source fifo instances into one downstream fifo.

---
 rtl/fifo_rr_scheduler.sv | 111 +++++++++++
 1 files changed

// File: rtl/fifo_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rr_scheduler
// Description : Round-robin drain of four source fifos into one downstream
//               fifo. Each forwarded word is tagged with its source lane.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rr_scheduler #(
    parameter int BITNUMBER = 8,
    parameter int NLANES    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NLANES-1:0]             Fifo_empty,
    input  logic [NLANES-1:0]             almost_empty,
    input  logic [NLANES-1:0]             Fifo_error,
    input  logic [NLANES*BITNUMBER-1:0]   Fifo_Data_out,
    input  logic                          almost_full,
    output logic [NLANES-1:0]             Fifo_rd,
    output logic [BITNUMBER-1:0]          Data_out,
    output logic                          Data_wr,
    output logic [1:0]                    Data_src,
    output logic                          active,
    output logic                          sched_error
);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [1:0]             r_ptr;
    logic [NLANES-1:0]      r_block;
    logic [BITNUMBER-1:0]   r_data_out;
    logic                   r_data_wr;
    logic [1:0]             r_data_src;
    logic                   r_sched_error;

    logic [NLANES-1:0]      w_elig;
    logic                   w_found;
    logic [1:0]             w_gidx;
    logic                   w_go;
    logic                   w_grant;
    logic [BITNUMBER-1:0]   w_word;

    // A lane popped at its last word shows a stale non-empty flag for one cycle.
    assign w_elig = ~Fifo_empty & ~r_block;

    // Pointer arithmetic is 2 bits wide, so the search wraps 3 -> 0 naturally.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = 2'd0;
        for (int k = 0; k < NLANES; k++) begin
            if (!w_found && w_elig[r_ptr + 2'(k)]) begin
                w_found = 1'b1;
                w_gidx  = r_ptr + 2'(k);
            end
        end
    end

    assign w_go    = enable && !almost_full && w_found;
    assign w_grant = (r_state == ST_ACTIVE) && w_go;
    assign w_word  = Fifo_Data_out[int'(w_gidx)*BITNUMBER +: BITNUMBER];

    always_comb begin
        Fifo_rd = '0;
        if (w_grant) begin
            Fifo_rd[w_gidx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_INIT;
            r_ptr         <= 2'd0;
            r_block       <= '0;
            r_data_out    <= '0;
            r_data_wr     <= 1'b0;
            r_data_src    <= 2'd0;
            r_sched_error <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT:   r_state <= ST_IDLE;
                ST_IDLE:   if (w_go)  r_state <= ST_ACTIVE;
                ST_ACTIVE: if (!w_go) r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase

            r_block       <= Fifo_rd & almost_empty;
            r_data_wr     <= w_grant;
            r_sched_error <= r_sched_error | (|Fifo_error);

            if (w_grant) begin
                r_ptr      <= w_gidx + 2'd1;
                r_data_out <= w_word;
                r_data_src <= w_gidx;
            end
        end
    end

    assign Data_out    = r_data_out;
    assign Data_wr     = r_data_wr;
    assign Data_src    = r_data_src;
    assign active      = (r_state == ST_ACTIVE);
    assign sched_error = r_sched_error;

endmodule
`default_nettype wire
